// File: rtl/seg_scan_display_ctrl.sv
// Multiplexed 7-segment driver: two GROUP-digit fields loaded as binary values
// and converted to BCD by a bit-serial double-dabble FSM.
module seg_scan_display_ctrl #(
  parameter int unsigned GROUP       = 4,
  parameter int unsigned BIN_W       = 10,
  parameter int unsigned SCAN_DIV    = 5000,
  parameter int unsigned BLINK_TICKS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [BIN_W-1:0]     bin_in,
  input  logic                 field_sel,
  input  logic                 lz_en,
  input  logic [2*GROUP-1:0]   dp_mask,
  input  logic [2*GROUP-1:0]   blink_mask,
  output logic [1:0]           overflow,
  output logic [2*GROUP-1:0]   tub_sel,
  output logic [7:0]           tub_control1,
  output logic [7:0]           tub_control2
);

  localparam int unsigned NUM_DIGITS = 2 * GROUP;
  localparam int unsigned NIB_EST    = (BIN_W * 302 + 999) / 1000 + 1;
  localparam int unsigned NIB        = (NIB_EST > GROUP) ? NIB_EST : GROUP;
  localparam int unsigned ACC_W      = 4 * NIB;
  localparam int unsigned SW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW         = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned CW         = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, adj;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               fsel_q, fsel_d;
  logic               lzin_q, lzin_d;
  logic [3:0]         dig_q [NUM_DIGITS];
  logic [3:0]         dig_d [NUM_DIGITS];
  logic [1:0]         lz_q, lz_d;
  logic [1:0]         blank_q, blank_d;
  logic [1:0]         ovf_q, ovf_d;
  logic               hi_nz;
  logic [SW-1:0]      scan_q, scan_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic               phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      fsel_q  <= 1'b0;
      lzin_q  <= 1'b0;
      dig_q   <= '{default: 4'd0};
      lz_q    <= '0;
      blank_q <= '1;
      ovf_q   <= '0;
      scan_q  <= '0;
      presc_q <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      fsel_q  <= fsel_d;
      lzin_q  <= lzin_d;
      dig_q   <= dig_d;
      lz_q    <= lz_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
      scan_q  <= scan_d;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  // Converter FSM and field commit.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    fsel_d     = fsel_q;
    lzin_d     = lzin_q;
    dig_d      = dig_q;
    lz_d       = lz_q;
    blank_d    = blank_q;
    ovf_d      = ovf_q;
    load_ready = 1'b0;
    adj        = acc_q;
    hi_nz      = 1'b0;
    for (int unsigned k = GROUP; k < NIB; k++) begin
      if (acc_q[4*k +: 4] != 4'd0) hi_nz = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          bin_d   = bin_in;
          fsel_d  = field_sel;
          lzin_d  = lz_en;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        for (int unsigned k = 0; k < NIB; k++) begin
          if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        acc_d = {adj[ACC_W-2:0], bin_q[BIN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BIN_W - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        // Digit position 0 is the leftmost, i.e. the most significant nibble.
        for (int unsigned p = 0; p < GROUP; p++) begin
          if (fsel_q) dig_d[GROUP + p] = acc_q[4*(GROUP-1-p) +: 4];
          else        dig_d[p]         = acc_q[4*(GROUP-1-p) +: 4];
        end
        lz_d[fsel_q]    = lzin_q;
        blank_d[fsel_q] = 1'b0;
        ovf_d[fsel_q]   = hi_nz;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan prescaler, digit index and blink phase.
  always_comb begin
    presc_d = presc_q + PW'(1);
    scan_d  = scan_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      scan_d  = (scan_q == SW'(NUM_DIGITS - 1)) ? '0 : scan_q + SW'(1);
      if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'd0: glyph = 8'h3F;
      4'd1: glyph = 8'h06;
      4'd2: glyph = 8'h5B;
      4'd3: glyph = 8'h4F;
      4'd4: glyph = 8'h66;
      4'd5: glyph = 8'h6D;
      4'd6: glyph = 8'h7D;
      4'd7: glyph = 8'h07;
      4'd8: glyph = 8'h7F;
      4'd9: glyph = 8'h6F;
      default: glyph = 8'h00;
    endcase
  endfunction

  logic [NUM_DIGITS-1:0] lead_blank;
  logic                  all_zero;
  logic                  cur_f;
  logic [7:0]            dp_bits;
  logic [7:0]            code;

  // A digit is a suppressible leading zero when it and everything left of it
  // in its field is zero; the rightmost digit is never suppressed.
  always_comb begin
    lead_blank = '0;
    all_zero   = 1'b1;
    for (int unsigned f = 0; f < 2; f++) begin
      all_zero = 1'b1;
      for (int unsigned p = 0; p < GROUP; p++) begin
        if (dig_q[f*GROUP + p] != 4'd0) all_zero = 1'b0;
        if (all_zero && (p != GROUP - 1)) lead_blank[f*GROUP + p] = 1'b1;
      end
    end
  end

  always_comb begin
    cur_f   = (scan_q >= SW'(GROUP));
    dp_bits = {dp_mask[scan_q], 7'b0};
    code    = 8'h00;
    if (blank_q[cur_f])                         code = 8'h00;
    else if (blink_mask[scan_q] && phase_q)     code = 8'h00;
    else if (ovf_q[cur_f])                      code = 8'h40 | dp_bits;
    else if (lz_q[cur_f] && lead_blank[scan_q]) code = dp_bits;
    else                                        code = glyph(dig_q[scan_q]) | dp_bits;
  end

  assign tub_sel      = NUM_DIGITS'(1) << scan_q;
  assign tub_control1 = cur_f ? 8'h00 : code;
  assign tub_control2 = cur_f ? code : 8'h00;
  assign overflow     = ovf_q;

endmodule
